// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg -- shared definitions for the instruction-fetch slice.
//
// Contents:
//   DEFAULT_RESET_PC  default first fetch address
//   PC_STEP           byte increment between sequential fetches
//   fetch_state_t     fetch FSM state encoding (HALT only with IF_ALIGN_CHECK_EN)
//   fq_entry_t        fetch-queue entry {pc, inst}
//   next_pc()         sequential PC helper (wraps modulo 2^32)
//
// Configuration macro: IF_ALIGN_CHECK_EN adds the HALT state.
// ---------------------------------------------------------------------------
package if_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    // 32-bit add: 32'hFFFF_FFFC + 4 wraps to 0.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue -- circular FIFO of fetched {pc, inst} entries.
//
// Parameters:
//   DEPTH      number of entries (power of two: 2 or 4)
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset; clears pointers, count, contents
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        consume the head
//   flush      empty the queue; wins over push and pop
//   head       entry at the head of the queue
//   count      number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_queue
    import if_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    input  logic          flush,
    output fq_entry_t     head,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fq_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Guarded so an out-of-contract push or pop can never corrupt the pointers.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL_CNT) || do_pop);
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction fetch unit with a small output queue.
//
// Issues one word read at a time to instruction memory, queues the returned
// {pc, inst} pairs and presents them to the decoder. A redirect flushes the
// queue, retargets the PC and discards any response still in flight.
//
// Parameters:
//   RESET_PC          first fetch address after reset
//   QUEUE_DEPTH       output queue depth (2 or 4)
// Ports:
//   clk               clock, rising edge
//   rst_n             synchronous active-low reset
//   imem_req_valid    read request pending
//   imem_req_ready    memory accepts the request
//   imem_req_addr     request address (the current pc)
//   imem_rsp_valid    read data returned (always accepted)
//   imem_rsp_data     returned instruction word
//   inst_valid        queue head valid toward the decoder
//   inst_ready        decoder consumes the head
//   inst              instruction word at the head
//   inst_pc           pc of the head
//   redirect_valid    branch / jump / trap redirect
//   redirect_pc       redirect target
//   fetch_misaligned  sticky misaligned-target flag (IF_ALIGN_CHECK_EN only)
//
// Configuration macro: IF_ALIGN_CHECK_EN traps misaligned redirect targets in
// a HALT state; without it the low two target bits are forced to zero.
// ---------------------------------------------------------------------------
module inst_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
`ifdef IF_ALIGN_CHECK_EN
    output logic        fetch_misaligned,
`endif
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(QUEUE_DEPTH);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   req_pc;        // address of the outstanding request
    logic [CW-1:0] count;
    fq_entry_t     push_entry;
    fq_entry_t     head;
    logic          req_fire;
    logic          q_push;
    logic          q_pop;
    logic [31:0]   redirect_target;
    fetch_state_t  redirect_resume;  // state to enter once a redirect needs no drain
    fetch_state_t  drain_resume;     // state to enter after the stale response

`ifdef IF_ALIGN_CHECK_EN
    logic misaligned_q;
    logic redirect_misaligned;

    assign redirect_misaligned = redirect_pc[1:0] != 2'b00;
    assign redirect_target     = redirect_pc;
    assign redirect_resume     = redirect_misaligned ? HALT : REQ;
    assign drain_resume        = misaligned_q ? HALT : REQ;
    assign fetch_misaligned    = misaligned_q;
`else
    assign redirect_target     = redirect_pc & 32'hFFFF_FFFC;
    assign redirect_resume     = REQ;
    assign drain_resume        = REQ;
`endif

    // Room for one more entry is checked before issuing; with a single
    // outstanding request this guarantees a response never meets a full queue.
    assign imem_req_valid = rst_n && (state == REQ) && (count < DEPTH_CNT) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign q_push = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign q_pop  = inst_valid && inst_ready;

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = req_pc;
        push_entry.inst = imem_rsp_data;
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign inst_valid = count != '0;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
`ifdef IF_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else if (redirect_valid) begin
            pc <= redirect_target;
`ifdef IF_ALIGN_CHECK_EN
            misaligned_q <= redirect_misaligned;
`endif
            case (state)
                // A response in the redirect cycle is the stale one: drop it and
                // skip DRAIN. In DRAIN this also avoids waiting for a response
                // that will never come.
                WAIT, DRAIN: state <= imem_rsp_valid ? redirect_resume : DRAIN;
                default:     state <= redirect_resume;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (req_fire) begin
                        pc     <= next_pc(pc);
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state <= drain_resume;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch -- bench for inst_fetch (QUEUE_DEPTH=2, RESET_PC=0).
// A memory model answers requests after a programmable latency; a request
// monitor and an instruction monitor compare against expectation queues
// filled by the directed stimulus.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IF_ALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int lat      = 1;

    logic [31:0] exp_req[$];
    logic [31:0] exp_inst[$];

    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = '0;

    inst_fetch #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .redirect_valid   (redirect_valid),
`ifdef IF_ALIGN_CHECK_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .redirect_pc      (redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Memory model plus request monitor. Inputs change on negedge; sampling
    // happens 1 time unit before the rising edge.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            pend           = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_DEAD;
        end else if (pend && pcnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(paddr);
            pend           = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_DEAD;
            if (pend) pcnt--;
        end
        #4;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            hs_cnt++;
            if (exp_req.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_request: got %h, required none", imem_req_addr);
            end else begin
                check("req_addr", imem_req_addr, exp_req.pop_front());
            end
            pend  = 1'b1;
            pcnt  = lat;
            paddr = imem_req_addr;
        end
    end

    // Decoder-side monitor.
    always begin
        @(negedge clk);
        #4;
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_inst.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_inst: got pc %h, required none", inst_pc);
            end else begin
                logic [31:0] e;
                e = exp_inst.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst", inst, word(e));
            end
        end
    end

    task automatic issue(input int n);
        int target;
        target = hs_cnt + n;
        @(negedge clk);
        imem_req_ready = 1'b1;
        for (int k = 0; k < 60 && hs_cnt < target; k++) @(negedge clk);
        imem_req_ready = 1'b0;
        check("issue_handshakes", 32'(hs_cnt), 32'(target));
    endtask

    task automatic redirect(input logic [31:0] p);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = p;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int start;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        // Redirect held during reset must lose to reset.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Reset
        repeat (2) @(negedge clk);
        #1;
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
`ifdef IF_ALIGN_CHECK_EN
        check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;

        // Sequential fetch from reset PC
        exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
        exp_inst.push_back(32'h0); exp_inst.push_back(32'h4); exp_inst.push_back(32'h8);
        issue(3);
        repeat (4) @(negedge clk);

        // Full queue: two entries, then requests stop
        inst_ready = 1'b0;
        exp_req.push_back(32'hC); exp_req.push_back(32'h10);
        exp_inst.push_back(32'hC); exp_inst.push_back(32'h10); exp_inst.push_back(32'h14);
        start = hs_cnt;
        imem_req_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("full_hs_count", 32'(hs_cnt - start), 32'd2);
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        check("full_inst_pc", inst_pc, 32'hC);
        exp_req.push_back(32'h14);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        for (int k = 0; k < 20 && hs_cnt < start + 3; k++) @(negedge clk);
        imem_req_ready = 1'b0;
        check("resume_hs_count", 32'(hs_cnt - start), 32'd3);
        repeat (3) @(negedge clk);
        inst_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Redirect in WAIT, response 3 cycles later: goes through DRAIN
        redirect(32'h8);
        lat = 3;
        exp_req.push_back(32'h8); exp_req.push_back(32'h100);
        exp_inst.push_back(32'h100);
        issue(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("drain_req_valid", 32'(imem_req_valid), 32'd0);
        check("drain_inst_valid", 32'(inst_valid), 32'd0);
        lat = 1;
        issue(1);
        repeat (3) @(negedge clk);

        // Redirect in WAIT with same-cycle response
        exp_req.push_back(32'h104); exp_req.push_back(32'h300);
        exp_inst.push_back(32'h300);
        issue(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        issue(1);
        repeat (3) @(negedge clk);

        // Simultaneous push and pop with one entry queued
        inst_ready = 1'b0;
        exp_req.push_back(32'h304); exp_req.push_back(32'h308);
        exp_inst.push_back(32'h304); exp_inst.push_back(32'h308);
        issue(1);
        repeat (2) @(negedge clk);
        issue(1);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        check("pp_inst_valid", 32'(inst_valid), 32'd1);
        check("pp_inst_pc", inst_pc, 32'h308);
        check("pp_inst", inst, word(32'h308));
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        check("pp_empty", 32'(inst_valid), 32'd0);

        // Pop coinciding with redirect: handshake completes, queue emptied
        exp_req.push_back(32'h30C); exp_req.push_back(32'h310);
        exp_inst.push_back(32'h30C);
        issue(2);
        repeat (2) @(negedge clk);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        @(negedge clk);
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("popflush_inst_valid", 32'(inst_valid), 32'd0);

        // PC wrap
        inst_ready = 1'b1;
        redirect(32'hFFFF_FFFC);
        exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0);
        exp_inst.push_back(32'hFFFF_FFFC); exp_inst.push_back(32'h0);
        issue(2);
        repeat (3) @(negedge clk);

        // Misaligned redirect
        redirect(32'h102);
`ifdef IF_ALIGN_CHECK_EN
        #1;
        check("mis_flag_set", 32'(fetch_misaligned), 32'd1);
        start = hs_cnt;
        imem_req_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("halt_hs_count", 32'(hs_cnt - start), 32'd0);
        check("halt_req_valid", 32'(imem_req_valid), 32'd0);
        imem_req_ready = 1'b0;
        exp_req.push_back(32'h200);
        exp_inst.push_back(32'h200);
        redirect(32'h200);
        #1;
        check("mis_flag_clear", 32'(fetch_misaligned), 32'd0);
        issue(1);
`else
        exp_req.push_back(32'h100);
        exp_inst.push_back(32'h100);
        issue(1);
`endif
        repeat (4) @(negedge clk);

        check("pending_requests", 32'(exp_req.size()), 32'd0);
        check("pending_insts", 32'(exp_inst.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required test end");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset SHALL be RESET_PC.
REQ-002 Parameter QUEUE_DEPTH, default 2: the output queue SHALL hold QUEUE_DEPTH entries; legal values are 2 and 4.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1: reset SHALL be synchronous and active-low.
REQ-005 Port imem_req_valid, output, 1: an instruction-memory read request is pending.
REQ-006 Port imem_req_ready, input, 1: memory accepts the request.
REQ-007 Port imem_req_addr, output, 32: the word address of the request.
REQ-008 Port imem_rsp_valid, input, 1: read data is returned; the block SHALL accept it every cycle, with no backpressure.
REQ-009 Port imem_rsp_data, input, 32: the returned instruction word.
REQ-010 Port inst_valid, output, 1: the queue head is valid toward the decoder.
REQ-011 Port inst_ready, input, 1: the decoder consumes the queue head.
REQ-012 Port inst, output, 32: the instruction word at the queue head (this drives the decoder's inst input).
REQ-013 Port inst_pc, output, 32: the PC of the queue head.
REQ-014 Port redirect_valid, input, 1: a branch, jump or trap redirect.
REQ-015 Port redirect_pc, input, 32: the redirect target.
REQ-016 Port fetch_misaligned, output, 1: sticky misaligned-target flag; present only under IF_ALIGN_CHECK_EN.

Function
REQ-017 The FSM SHALL have states REQ, WAIT and DRAIN; state HALT exists only under IF_ALIGN_CHECK_EN.
REQ-018 imem_req_valid SHALL equal (state==REQ && count<QUEUE_DEPTH && !redirect_valid), and imem_req_addr SHALL equal pc.
REQ-019 On a request handshake (valid && ready), pc SHALL become pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0, and the state SHALL go REQ->WAIT.
REQ-020 At most one request SHALL be outstanding.
REQ-021 In WAIT, imem_rsp_valid SHALL push {req_addr, imem_rsp_data} into the queue and move the state WAIT->REQ; fetch-to-queue latency is therefore memory latency + 1 cycle.
REQ-022 A push SHALL never find the queue full; the request gating in REQ-018 guarantees this.
REQ-023 Pop SHALL occur on inst_valid && inst_ready; inst_valid SHALL equal (count!=0).
REQ-024 A simultaneous push and pop SHALL leave count unchanged, and the data order SHALL be preserved.
REQ-025 Redirect SHALL have highest priority: pc <= redirect_pc and count <= 0, so inst_valid is low in the next cycle.
REQ-026 A pop coinciding with a redirect SHALL complete the decoder handshake, but the queue SHALL still be emptied.
REQ-027 Redirect while in WAIT without a same-cycle response SHALL go WAIT->DRAIN.
REQ-028 Redirect while in WAIT with a same-cycle response SHALL discard that response and go to REQ.
REQ-029 In DRAIN, the next imem_rsp_valid SHALL be discarded, with no push, and the state SHALL go DRAIN->REQ.
REQ-030 A redirect while in DRAIN SHALL update pc and remain in DRAIN.
REQ-031 Redirect while in REQ SHALL stay in REQ; no request is issued in the redirect cycle.

Reset
REQ-032 While rst_n==0 at a clock edge, the block SHALL reset as follows:
- pc SHALL be RESET_PC, count 0, state REQ.
- inst_valid, imem_req_valid and fetch_misaligned SHALL be 0.
- inst, inst_pc and the queue contents SHALL be 0.
REQ-033 Reset SHALL override a concurrent redirect.
REQ-034 A response arriving in the first cycle after reset SHALL be ignored.
REQ-035 Reset asserted while in WAIT or DRAIN SHALL drop the outstanding request; the memory side SHALL be reset together with this block.

Configuration
REQ-036 With macro IF_ALIGN_CHECK_EN defined, misaligned redirects SHALL be trapped:
- A redirect with redirect_pc[1:0]!=0 SHALL set fetch_misaligned and enter HALT, where no requests are issued.
- The stale response SHALL be discarded first via DRAIN when the redirect arrives in WAIT.
- An aligned redirect SHALL clear the flag and leave HALT.
REQ-037 Without IF_ALIGN_CHECK_EN, the fetch_misaligned port and HALT state SHALL be absent, and redirect_pc[1:0] SHALL be forced to 2'b00.

Structure
REQ-038 Package if_pkg SHALL hold the following shared definitions:
- fetch_state_t, the FSM state enum.
- fq_entry_t, a struct of {pc, inst}.
- DEFAULT_RESET_PC.
- PC_STEP = 4.
REQ-039 Sub-module fetch_queue SHALL implement the queue:
- A circular FIFO of fq_entry_t with push, pop, flush and count.
- Flush SHALL have priority over push and pop.

Verification
REQ-040 Reset scenario:
- Stimulus: rst_n low for 2 cycles, then high; imem_req_ready=1; 1-cycle response latency.
- Required: first imem_req_addr=32'h0, then 32'h4 and 32'h8, with inst_pc values matching in order.
REQ-041 Full-queue scenario:
- Stimulus: inst_ready=0 with QUEUE_DEPTH=2.
- Required: exactly 2 responses queued, then imem_req_valid=0.
- Required: after inst_ready=1 for one cycle, fetching resumes.
REQ-042 Redirect-during-WAIT scenario:
- Stimulus: redirect to 32'h100 while in WAIT for 32'h8, with the response arriving 3 cycles later.
- Required: the 32'h8 data is never seen on inst, and the next request is 32'h100.
REQ-043 Simultaneous pop and push scenario:
- Stimulus: pop and push in the same cycle with count=1.
- Required: count stays 1, and inst shows the older word first.
REQ-044 Wrap scenario:
- Stimulus: redirect_pc=32'hFFFF_FFFC.
- Required: the next request is 32'h0.
REQ-045 Misaligned-redirect scenario, run both with and without IF_ALIGN_CHECK_EN:
- Stimulus: redirect_pc=32'h102.
- With the macro: fetch_misaligned=1 and no requests issued until a redirect to 32'h200.
- Without the macro: a request to 32'h100.
